tff_updown_counter: RTL

TFF_UPDOWN_COUNTER -- requirements
Module: tff_updown_counter

---
 rtl/tff_updown_counter.sv | 97 +++++++++
 1 files changed

// File: rtl/tff_updown_counter.sv
// Modulo-MOD up/down counter whose bits are T flip-flops driven by a toggle vector.
// Registered terminal-count pulse on wrap and a sticky wrap flag with synchronous clear.
module tff_updown_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] t_up, t_dn;
  logic [WIDTH-1:0] load_val;
  logic             all_ones, all_zeros;
  logic             wrap;

  // Ripple-style toggle terms: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    t_up      = '0;
    t_dn      = '0;
    all_ones  = 1'b1;
    all_zeros = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t_up[i]   = all_ones;
      t_dn[i]   = all_zeros;
      all_ones  = all_ones & q_q[i];
      all_zeros = all_zeros & ~q_q[i];
    end
  end

  always_comb begin
    t        = '0;
    wrap     = 1'b0;
    load_val = (din > MAX) ? MAX : din;
    if (load) begin
      t = q_q ^ load_val;
    end else if (en) begin
      if (up) begin
        if (q_q >= MAX) begin
          t    = q_q;
          wrap = 1'b1;
        end else begin
          t = t_up;
        end
      end else begin
        if (q_q == '0) begin
          t    = MAX;
          wrap = 1'b1;
        end else begin
          t = t_dn;
        end
      end
    end
  end

  // A wrap on the same edge as clr_ovf keeps the flag set.
  always_comb begin
    q_d   = q_q ^ t;
    tc_d  = wrap;
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (wrap)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign qn  = ~q_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule
